// File: rtl/mul_accumulator.sv
// rtl/mul_accumulator.sv - saturating block accumulator for the multiplier product stream
//
// Sums BLOCK_LEN accepted products into a saturating unsigned ACC_W-bit
// accumulator and presents each completed block on a valid/ready port.
// Products offered while a block result is waiting are discarded and
// recorded in the sticky drop flag.
//
// Ports:
//   clk          clock, all state changes on rising edge
//   reset        asynchronous active-high reset, clears all state
//   in_val       product valid (multiplier val)
//   in_res       product value, unsigned ACC_W bits
//   in_overflow  multiplier overflow for this product
//   in_ready     high when a product will be accepted
//   clear        synchronous flush of accumulator, pending result and drop
//   out_valid    block result available
//   out_ready    consumer accepts result
//   out_sum      saturated block sum
//   out_sat      block saturated or contained an overflowed product
//   out_count    products in the presented block
//   drop         sticky: a product arrived while in_ready was low
module mul_accumulator #(
    parameter int ACC_W     = 64,
    parameter int BLOCK_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    input  logic [ACC_W-1:0] in_res,
    input  logic             in_overflow,
    output logic             in_ready,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_count,
    output logic             drop
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    // One extra bit catches the carry out of the unsigned add.
    logic [ACC_W:0]   sum_wide;
    logic             add_sat;
    logic [ACC_W-1:0] acc_next;
    logic             sat_next;
    logic             last;

    assign sum_wide = {1'b0, acc} + {1'b0, in_res};
    assign add_sat  = sum_wide[ACC_W] | in_overflow;
    assign acc_next = add_sat ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    assign sat_next = sat | add_sat;
    assign last     = (cnt == CNT_W'(BLOCK_LEN - 1));

    // Decoded from the state register alone so the upstream handshake
    // never depends combinationally on in_val.
    assign in_ready = (state == ACCUM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
            out_count <= '0;
            drop      <= 1'b0;
        end else if (clear) begin
            // A product offered alongside clear is discarded silently.
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            drop      <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_val) begin
                        if (last) begin
                            out_sum   <= acc_next;
                            out_sat   <= sat_next;
                            out_count <= CNT_W'(BLOCK_LEN);
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            sat       <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt + 1'b1;
                            sat <= sat_next;
                        end
                    end
                end
                HOLD: begin
                    // in_ready is low here, so any offered product is lost.
                    if (in_val) begin
                        drop <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_accumulator.sv
// tb/tb_mul_accumulator.sv - directed self-checking bench for mul_accumulator
module tb_mul_accumulator;

    localparam int ACC_W = 64;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_val;
    logic [ACC_W-1:0] in_res;
    logic             in_overflow;
    logic             in_ready;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_sat;
    logic [CNT_W-1:0] out_count;
    logic             drop;

    int checks = 0;
    int errors = 0;

    mul_accumulator #(
        .ACC_W    (ACC_W),
        .BLOCK_LEN(8),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_val     (in_val),
        .in_res     (in_res),
        .in_overflow(in_overflow),
        .in_ready   (in_ready),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_sat    (out_sat),
        .out_count  (out_count),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer n consecutive products of value v; product index ovf_idx carries overflow.
    task automatic send(input int n, input logic [63:0] v, input int ovf_idx);
        for (int i = 0; i < n; i++) begin
            in_val      = 1'b1;
            in_res      = v;
            in_overflow = (i == ovf_idx);
            tick();
        end
        in_val      = 1'b0;
        in_overflow = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        in_val      = 1'b0;
        in_res      = '0;
        in_overflow = 1'b0;
        clear       = 1'b0;
        out_ready   = 1'b1;
        tick();
        check_eq("rst_in_ready",  in_ready,  1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_sum",   out_sum,   0);
        check_eq("rst_out_sat",   out_sat,   0);
        check_eq("rst_out_count", out_count, 0);
        check_eq("rst_drop",      drop,      0);
        reset = 1'b0;
        tick();

        // Block of 8 x 2688 with the consumer always ready.
        send(8, 64'd2688, -1);
        check_eq("b1_valid", out_valid, 1);
        check_eq("b1_ready_low", in_ready, 0);
        check_eq("b1_sum", out_sum, 64'd21504);
        check_eq("b1_sat", out_sat, 0);
        check_eq("b1_count", out_count, 8);
        tick();
        check_eq("b1_valid_1cyc", out_valid, 0);
        check_eq("b1_ready_back", in_ready, 1);

        // Carry out saturates the block; the following block starts clean.
        send(8, 64'hFFFF_FFFF_0000_0000, -1);
        check_eq("b2_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("b2_sat", out_sat, 1);
        tick();
        send(8, 64'd1, -1);
        check_eq("b3_sum", out_sum, 64'd8);
        check_eq("b3_sat", out_sat, 0);
        tick();

        // Overflowed third product forces all-ones for the rest of the block.
        send(8, 64'd5, 2);
        check_eq("b4_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("b4_sat", out_sat, 1);
        tick();

        // Back-pressure: products during HOLD are dropped, result stays put.
        out_ready = 1'b0;
        send(8, 64'd2, -1);
        check_eq("b5_sum", out_sum, 64'd16);
        send(2, 64'd100, -1);
        check_eq("b5_drop", drop, 1);
        check_eq("b5_sum_held", out_sum, 64'd16);
        check_eq("b5_valid_held", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check_eq("b5_valid_low", out_valid, 0);
        send(8, 64'd7, -1);
        check_eq("b6_sum", out_sum, 64'd56);
        tick();

        // clear flushes drop and a partial block; a product alongside it is lost quietly.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_drop", drop, 0);
        send(4, 64'd10, -1);
        clear  = 1'b1;
        in_val = 1'b1;
        in_res = 64'd10;
        tick();
        clear  = 1'b0;
        in_val = 1'b0;
        check_eq("clr_ready", in_ready, 1);
        check_eq("clr_drop2", drop, 0);
        send(8, 64'd1, -1);
        check_eq("b7_sum", out_sum, 64'd8);
        check_eq("b7_drop", drop, 0);
        tick();

        // Asynchronous reset between edges discards a partial block.
        send(5, 64'd9, -1);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_in_ready",  in_ready,  1);
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_out_sum",   out_sum,   0);
        check_eq("arst_out_sat",   out_sat,   0);
        check_eq("arst_out_count", out_count, 0);
        check_eq("arst_drop",      drop,      0);
        #1 reset = 1'b0;
        tick();
        send(8, 64'd3, -1);
        check_eq("b8_sum", out_sum, 64'd24);
        check_eq("b8_count", out_count, 8);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
